// File: rtl/control_fsm_mips.sv
// Multicycle MIPS-subset control unit.
// The FSM walks each instruction through FETCH, DECODE, EXECUTE and, when
// needed, MEMORY and WRITEBACK. Unsupported encodings park it in ILLEGAL
// until reset. Datapath controls come from the state and the latched
// instruction word. The only exception is the PC strobe in MEMORY, which
// waits for the memory handshake.
module control_fsm_mips #(
    parameter logic [5:0] ALU_ADD = 6'b000000,
    parameter logic [5:0] ALU_SUB = 6'b000001,
    parameter logic [5:0] ALU_AND = 6'b000100,
    parameter logic [5:0] ALU_OR  = 6'b001000,
    parameter logic [5:0] ALU_SLT = 6'b010001
) (
    input  logic        in_clk,
    input  logic        in_reset,
    input  logic [31:0] in_instruction,
    input  logic        in_run,
    input  logic        in_mem_ready,
    output logic        out_r_1_en,
    output logic        out_r_2_en,
    output logic        out_w_en,
    output logic        out_reg_dst,
    output logic        out_alu_src,
    output logic        out_mem_to_reg,
    output logic        out_is_branch,
    output logic        out_is_jump,
    output logic        out_mem_write,
    output logic [5:0]  out_alu_control,
    output logic        out_pc_en,
    output logic [2:0]  out_state,
    output logic        out_illegal,
    output logic [31:0] out_retired
);

    // State encodings are visible on out_state, so they are fixed values.
    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_ILLEGAL   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        funct_ok;
    logic [5:0]  funct_alu;
    logic        is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, is_legal;
    logic        pc_en;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // Map the R-type funct field to an ALU code and flag unsupported functs.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // An R-type opcode with an unknown funct is treated as unsupported.
    // The class flags are therefore mutually exclusive and all zero for
    // illegal words.
    assign is_rtype = (opcode == OP_RTYPE) && funct_ok;
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_j     = (opcode == OP_J);
    assign is_legal = is_rtype | is_lw | is_sw | is_beq | is_addi | is_j;

    // State register. Reset is asynchronous, so every output derived from
    // the state drops as soon as in_reset rises.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register and retired-instruction counter.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Capture the instruction only when leaving FETCH. Count each PC
    // advance, and let the counter wrap naturally at 2^32.
    always_comb begin
        ir_d      = ir_q;
        retired_d = retired_q;
        if ((state_q == S_FETCH) && in_run) begin
            ir_d = in_instruction;
        end
        if (pc_en) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (in_run) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXECUTE : S_ILLEGAL;
            end
            S_EXECUTE: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEMORY;
                end else if (is_rtype || is_addi) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMORY: begin
                if (in_mem_ready) begin
                    state_d = is_lw ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end
            // Encodings 5 and 6 are unreachable; recover to FETCH.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode. The per-instruction selects are held from DECODE to
    // the end of the instruction. Strobes fire only in their own state.
    always_comb begin
        out_r_1_en      = 1'b0;
        out_r_2_en      = 1'b0;
        out_w_en        = 1'b0;
        out_reg_dst     = 1'b0;
        out_alu_src     = 1'b0;
        out_mem_to_reg  = 1'b0;
        out_is_branch   = 1'b0;
        out_is_jump     = 1'b0;
        out_mem_write   = 1'b0;
        out_alu_control = ALU_ADD;
        out_illegal     = 1'b0;
        pc_en           = 1'b0;
        case (state_q)
            S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK: begin
                if (is_legal) begin
                    out_r_1_en     = ~is_j;
                    out_r_2_en     = is_rtype | is_sw | is_beq;
                    out_reg_dst    = is_rtype;
                    out_alu_src    = is_lw | is_sw | is_addi;
                    out_mem_to_reg = is_lw;
                    if (is_rtype) begin
                        out_alu_control = funct_alu;
                    end else if (is_beq) begin
                        out_alu_control = ALU_SUB;
                    end
                end
                if (state_q == S_EXECUTE) begin
                    out_is_branch = is_beq;
                    out_is_jump   = is_j;
                    pc_en         = is_beq | is_j;
                end
                if (state_q == S_MEMORY) begin
                    out_mem_write = is_sw;
                    pc_en         = is_sw & in_mem_ready;
                end
                if (state_q == S_WRITEBACK) begin
                    out_w_en = 1'b1;
                    pc_en    = 1'b1;
                end
            end
            S_ILLEGAL: begin
                out_illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign out_pc_en   = pc_en;
    assign out_state   = state_q;
    assign out_retired = retired_q;

endmodule

// File: tb/tb_control_fsm_mips.sv
// Self-checking bench for control_fsm_mips. The stimulus is randomised.
// For each instruction a reference model works out the expected state walk
// and the expected outputs from the instruction class. A negedge process
// then compares every DUT output against that model.
module tb_control_fsm_mips;

    localparam logic [5:0] A_ADD = 6'b000000;
    localparam logic [5:0] A_SUB = 6'b000001;
    localparam logic [5:0] A_AND = 6'b000100;
    localparam logic [5:0] A_OR  = 6'b001000;
    localparam logic [5:0] A_SLT = 6'b010001;

    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_BAD = 6;

    typedef struct packed {
        logic [2:0] st;
        logic       r1, r2, w, rd, as, m2r, br, jp, mw;
        logic [5:0] alu;
        logic       pc, ill;
    } exp_t;

    logic        in_clk = 1'b0;
    logic        in_reset = 1'b0;
    logic [31:0] in_instruction = 32'd0;
    logic        in_run = 1'b0;
    logic        in_mem_ready = 1'b0;
    logic        out_r_1_en, out_r_2_en, out_w_en, out_reg_dst, out_alu_src;
    logic        out_mem_to_reg, out_is_branch, out_is_jump, out_mem_write;
    logic [5:0]  out_alu_control;
    logic        out_pc_en;
    logic [2:0]  out_state;
    logic        out_illegal;
    logic [31:0] out_retired;

    control_fsm_mips dut (
        .in_clk          (in_clk),
        .in_reset        (in_reset),
        .in_instruction  (in_instruction),
        .in_run          (in_run),
        .in_mem_ready    (in_mem_ready),
        .out_r_1_en      (out_r_1_en),
        .out_r_2_en      (out_r_2_en),
        .out_w_en        (out_w_en),
        .out_reg_dst     (out_reg_dst),
        .out_alu_src     (out_alu_src),
        .out_mem_to_reg  (out_mem_to_reg),
        .out_is_branch   (out_is_branch),
        .out_is_jump     (out_is_jump),
        .out_mem_write   (out_mem_write),
        .out_alu_control (out_alu_control),
        .out_pc_en       (out_pc_en),
        .out_state       (out_state),
        .out_illegal     (out_illegal),
        .out_retired     (out_retired)
    );

    always #5 in_clk = ~in_clk;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_cur;
    bit          exp_valid = 1'b0;
    logic [31:0] model_retired = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction class straight from the opcode/funct tables.
    function automatic int classify(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                             fn == 6'h25 || fn == 6'h2A) ? C_R : C_BAD;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h08:   return C_ADDI;
            6'h02:   return C_J;
            default: return C_BAD;
        endcase
    endfunction

    function automatic logic [5:0] r_alu(input logic [31:0] w);
        logic [5:0] fn;
        fn = w[5:0];
        case (fn)
            6'h22:   return A_SUB;
            6'h24:   return A_AND;
            6'h25:   return A_OR;
            6'h2A:   return A_SLT;
            default: return A_ADD;
        endcase
    endfunction

    // Expected outputs for one cycle. st is the state the instruction is in,
    // and last marks the cycle that ends the instruction.
    function automatic exp_t mk(input int st, input int cls, input logic [31:0] w, input bit last);
        exp_t e;
        e     = '0;
        e.st  = 3'(st);
        e.alu = A_ADD;
        if (st == 7) begin
            e.ill = 1'b1;
        end else if (st != 0 && cls != C_BAD) begin
            e.r1  = (cls != C_J);
            e.r2  = (cls == C_R || cls == C_SW || cls == C_BEQ);
            e.rd  = (cls == C_R);
            e.as  = (cls == C_LW || cls == C_SW || cls == C_ADDI);
            e.m2r = (cls == C_LW);
            e.alu = (cls == C_R) ? r_alu(w) : (cls == C_BEQ) ? A_SUB : A_ADD;
            e.w   = (st == 4);
            e.mw  = (st == 3 && cls == C_SW);
            e.br  = (st == 2 && cls == C_BEQ);
            e.jp  = (st == 2 && cls == C_J);
            e.pc  = last;
        end
        return e;
    endfunction

    // Compare every meaningful cycle, midway between rising edges.
    always @(negedge in_clk) begin
        if (exp_valid) begin
            chk("state",      32'(out_state),       32'(exp_cur.st));
            chk("r_1_en",     32'(out_r_1_en),      32'(exp_cur.r1));
            chk("r_2_en",     32'(out_r_2_en),      32'(exp_cur.r2));
            chk("w_en",       32'(out_w_en),        32'(exp_cur.w));
            chk("reg_dst",    32'(out_reg_dst),     32'(exp_cur.rd));
            chk("alu_src",    32'(out_alu_src),     32'(exp_cur.as));
            chk("mem_to_reg", 32'(out_mem_to_reg),  32'(exp_cur.m2r));
            chk("is_branch",  32'(out_is_branch),   32'(exp_cur.br));
            chk("is_jump",    32'(out_is_jump),     32'(exp_cur.jp));
            chk("mem_write",  32'(out_mem_write),   32'(exp_cur.mw));
            chk("alu_ctl",    32'(out_alu_control), 32'(exp_cur.alu));
            chk("pc_en",      32'(out_pc_en),       32'(exp_cur.pc));
            chk("illegal",    32'(out_illegal),     32'(exp_cur.ill));
            chk("retired",    out_retired,          model_retired);
        end
    end

    // One clock with the given expectation; called at posedge+1.
    task automatic cyc(input exp_t e);
        exp_cur   = e;
        exp_valid = 1'b1;
        @(posedge in_clk);
        if (e.pc) model_retired = model_retired + 32'd1;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"},   32'(out_state), 32'd0);
        chk({tag, "_illegal"}, 32'(out_illegal), 32'd0);
        chk({tag, "_retired"}, out_retired, 32'd0);
        chk({tag, "_w_en"},    32'(out_w_en), 32'd0);
        chk({tag, "_pc_en"},   32'(out_pc_en), 32'd0);
        chk({tag, "_mem_wr"},  32'(out_mem_write), 32'd0);
        chk({tag, "_alu"},     32'(out_alu_control), 32'(A_ADD));
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        #2;
        in_reset = 1'b1;
        in_run   = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(posedge in_clk);
        #1;
        in_reset      = 1'b0;
        model_retired = 32'd0;
    endtask

    // Drive one instruction from FETCH to its end. An illegal instruction
    // stays in ILLEGAL for ill_cycles; the caller then resets. With abort_wb
    // set, reset is raised halfway through the WRITEBACK cycle.
    task automatic run_instr(input logic [31:0] w, input int idle, input int waits,
                             input int ill_cycles, input bit abort_wb);
        int cls;
        cls = classify(w);
        $display("instr %h class %0d idle %0d waits %0d abort %0d", w, cls, idle, waits, abort_wb);
        for (int i = 0; i < idle; i++) begin
            in_run = 1'b0; in_instruction = $urandom; in_mem_ready = 1'($urandom);
            cyc(mk(0, cls, w, 1'b0));
        end
        in_run = 1'b1; in_instruction = w;
        cyc(mk(0, cls, w, 1'b0));
        in_run = 1'($urandom); in_instruction = $urandom; in_mem_ready = 1'($urandom);
        cyc(mk(1, cls, w, 1'b0));
        if (cls == C_BAD) begin
            for (int i = 0; i < ill_cycles; i++) begin
                in_run = 1'($urandom); in_mem_ready = 1'($urandom);
                cyc(mk(7, cls, w, 1'b0));
            end
            return;
        end
        in_mem_ready = 1'($urandom);
        cyc(mk(2, cls, w, (cls == C_BEQ || cls == C_J)));
        if (cls == C_LW || cls == C_SW) begin
            for (int i = 0; i < waits; i++) begin
                in_mem_ready = 1'b0;
                cyc(mk(3, cls, w, 1'b0));
            end
            in_mem_ready = 1'b1;
            cyc(mk(3, cls, w, (cls == C_SW)));
        end
        if (cls == C_R || cls == C_ADDI || cls == C_LW) begin
            in_mem_ready = 1'($urandom);
            if (abort_wb) begin
                exp_cur   = mk(4, cls, w, 1'b1);
                exp_valid = 1'b1;
                @(negedge in_clk);
                #1;
                exp_valid = 1'b0;
                in_reset  = 1'b1;
                #1;
                chk("abort_w_en",    32'(out_w_en), 32'd0);
                chk("abort_pc_en",   32'(out_pc_en), 32'd0);
                chk("abort_state",   32'(out_state), 32'd0);
                chk("abort_retired", out_retired, 32'd0);
                @(posedge in_clk);
                #1;
                chk("abort_retired_edge", out_retired, 32'd0);
                in_reset      = 1'b0;
                model_retired = 32'd0;
            end else begin
                cyc(mk(4, cls, w, 1'b1));
            end
        end
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        logic [5:0]  fn;
        int          k;
        r = $urandom;
        k = int'($urandom_range(0, 5));
        case (k)
            0: begin
                case ($urandom_range(0, 4))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    default: fn = 6'h2A;
                endcase
                return {6'h00, r[25:6], fn};
            end
            1: return {6'h23, r[25:0]};
            2: return {6'h2B, r[25:0]};
            3: return {6'h04, r[25:0]};
            4: return {6'h08, r[25:0]};
            default: return {6'h02, r[25:0]};
        endcase
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] r;
        r = 32'hFC00_0000;
        for (int i = 0; i < 64; i++) begin
            r = $urandom;
            if (classify(r) == C_BAD) return r;
        end
        return 32'h0000_002B;
    endfunction

    initial begin
        exp_t pin;

        // Literal pins on the model itself.
        chk("pin_cls_add",  32'(classify(32'h0022_1820)), 32'(C_R));
        chk("pin_cls_lw",   32'(classify(32'h8C22_0004)), 32'(C_LW));
        chk("pin_cls_sw",   32'(classify(32'hAC22_0004)), 32'(C_SW));
        chk("pin_cls_beq",  32'(classify(32'h1022_0003)), 32'(C_BEQ));
        chk("pin_cls_j",    32'(classify(32'h0800_0010)), 32'(C_J));
        chk("pin_cls_bad",  32'(classify(32'hFC00_0000)), 32'(C_BAD));
        chk("pin_cls_badfn", 32'(classify(32'h0022_1821)), 32'(C_BAD));
        pin = mk(4, C_R, 32'h0022_1820, 1'b1);
        chk("pin_wb_add", 32'({pin.w, pin.rd, pin.pc, pin.alu}), 32'({3'b111, 6'b000000}));
        pin = mk(2, C_BEQ, 32'h1022_0003, 1'b1);
        chk("pin_ex_beq", 32'({pin.br, pin.alu}), 32'({1'b1, 6'b000001}));

        // Asynchronous reset before any clock edge.
        #1;
        in_reset = 1'b1;
        #1;
        check_reset_outputs("por");
        @(posedge in_clk);
        #1;
        in_reset = 1'b0;

        // add -> 0,1,2,4 then one retired instruction.
        run_instr(32'h0022_1820, 1, 0, 0, 1'b0);
        #1;
        chk("add_retired_lit", out_retired, 32'd1);
        // lw with two wait cycles, then sw without waits.
        run_instr(32'h8C22_0004, 0, 2, 0, 1'b0);
        run_instr(32'hAC22_0004, 0, 0, 0, 1'b0);

        // beq then j from a fresh reset leaves two retired.
        do_reset();
        run_instr(32'h1022_0003, 0, 0, 0, 1'b0);
        run_instr(32'h0800_0010, 0, 0, 0, 1'b0);
        #1;
        chk("beq_j_retired_lit", out_retired, 32'd2);

        // Unsupported opcode sits in ILLEGAL for 20 cycles.
        run_instr(32'hFC00_0000, 0, 0, 20, 1'b0);
        #1;
        chk("ill_state_lit", 32'(out_state), 32'd7);
        do_reset();

        // Reset raised in the middle of an add's WRITEBACK.
        run_instr(32'h0022_1820, 0, 0, 0, 1'b1);

        // Randomised instruction stream.
        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                run_instr(rand_illegal(), int'($urandom_range(0, 2)), 0,
                          int'($urandom_range(1, 4)), 1'b0);
                do_reset();
            end else begin
                run_instr(rand_legal(), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), 0, 1'b0);
            end
        end

        exp_valid = 1'b0;
        @(posedge in_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
